// File: rtl/des_block_serializer_pkg.sv
// Shared constants, FSM state type and PKCS#5 pad-check helper for the DES block serializer.
package des_pkg;

  localparam int BLK_W         = 64;
  localparam int BYTE_W        = 8;
  localparam int BYTES_PER_BLK = 8;

  typedef enum logic {
    IDLE,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [2:0] lim;
    logic       ok;
    logic       empty;
  } pad_res_t;

  // N is the last byte; bytes 8-N..7 must all equal N, and N must be 1..8.
  function automatic pad_res_t pad_check(input logic [1:BLK_W] blk);
    pad_res_t           r;
    logic [BYTE_W-1:0]  n;
    logic [BYTE_W-1:0]  rem;
    logic               match;
    n     = blk[BLK_W-BYTE_W+1:BLK_W];
    match = 1'b1;
    for (int i = 0; i < BYTES_PER_BLK; i++) begin
      if ((i >= BYTES_PER_BLK - int'(n)) && (blk[i*BYTE_W+1 +: BYTE_W] != n)) begin
        match = 1'b0;
      end
    end
    rem     = 8'd7 - n;
    r.ok    = (n >= 8'd1) && (n <= 8'd8) && match;
    r.empty = r.ok && (n == 8'd8);
    r.lim   = (r.ok && !r.empty) ? rem[2:0] : 3'd7;
    return r;
  endfunction

endpackage

// File: rtl/des_block_serializer_if.sv
// Block-in / byte-out stream bundle. Both sides use valid/ready: a transfer
// happens on a rising edge where valid & ready are both high; a source never
// drops valid or changes data until that transfer occurs.
interface des_block_serializer_if;
  import des_pkg::*;

  logic [1:BLK_W]  in_block;
  logic            in_valid;
  logic            in_last;
  logic            in_ready;
  logic [1:BYTE_W] out_byte;
  logic            out_valid;
  logic            out_last;
  logic            out_ready;
  logic            done;
  logic            pad_err;

  modport master (
    output in_block, in_valid, in_last, out_ready,
    input  in_ready, out_byte, out_valid, out_last, done, pad_err
  );

  modport slave (
    input  in_block, in_valid, in_last, out_ready,
    output in_ready, out_byte, out_valid, out_last, done, pad_err
  );

endinterface

// File: rtl/des_block_serializer_pad_check.sv
// Combinational PKCS#5 pad inspection of a decrypted block (used only with DES_PAD_STRIP_EN).
module des_pad_check
  import des_pkg::*;
(
  input  logic [1:BLK_W] in_block,
  output logic [2:0]     lim_out,
  output logic           pad_ok,
  output logic           empty_blk
);

  pad_res_t res;

  assign res       = pad_check(in_block);
  assign lim_out   = res.lim;
  assign pad_ok    = res.ok;
  assign empty_blk = res.empty;

endmodule

// File: rtl/des_block_serializer.sv
// Double-buffered 64-bit block to byte stream serializer, byte 0 first.
// Define DES_PAD_STRIP_EN to strip PKCS#5 padding from final blocks.
module des_block_serializer
  import des_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  des_block_serializer_if.slave bus,
  output state_t                dbg_state
);

  state_t          state, state_nxt;
  logic [1:BLK_W]  act, pend;
  logic [2:0]      cnt, lim, pend_lim;
  logic            act_last, act_empty;
  logic            pend_full, pend_last, pend_empty;
  logic            done_q;

  logic [2:0]      in_lim;
  logic            in_empty;

  logic            out_valid, blk_end, byte_hs, retire, shift;
  logic            accept, load_in, load_pend, load_from_pend;

`ifdef DES_PAD_STRIP_EN
  logic [2:0] pc_lim;
  logic       pc_ok, pc_empty, in_bad, pad_err_q;

  des_pad_check u_pad_check (
    .in_block  (bus.in_block),
    .lim_out   (pc_lim),
    .pad_ok    (pc_ok),
    .empty_blk (pc_empty)
  );

  assign in_lim   = bus.in_last ? pc_lim : 3'd7;
  assign in_empty = bus.in_last & pc_empty;
  assign in_bad   = bus.in_last & ~pc_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      pad_err_q <= 1'b0;
    end else if (accept && in_bad) begin
      pad_err_q <= 1'b1;
    end
  end

  assign bus.pad_err = pad_err_q;
`else
  assign in_lim      = 3'd7;
  assign in_empty    = 1'b0;
  assign bus.pad_err = 1'b0;
`endif

  // A fully-stripped block sits in ACT with nothing to send and retires at once.
  always_comb begin
    out_valid      = (state == DRAIN) && !act_empty;
    blk_end        = (cnt == lim);
    byte_hs        = out_valid && bus.out_ready;
    retire         = (state == DRAIN) && (act_empty || (byte_hs && blk_end));
    shift          = byte_hs && !blk_end;
    accept         = bus.in_valid && !pend_full;
    load_in        = accept && ((state == IDLE) || (retire && !pend_full));
    load_pend      = accept && !load_in;
    load_from_pend = retire && pend_full;

    state_nxt = state;
    if (load_in || load_from_pend) begin
      state_nxt = DRAIN;
    end else if (retire) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      act        <= '0;
      pend       <= '0;
      cnt        <= 3'd0;
      lim        <= 3'd7;
      pend_lim   <= 3'd7;
      act_last   <= 1'b0;
      act_empty  <= 1'b0;
      pend_full  <= 1'b0;
      pend_last  <= 1'b0;
      pend_empty <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= retire && act_last;

      if (load_in) begin
        act       <= bus.in_block;
        cnt       <= 3'd0;
        lim       <= in_lim;
        act_last  <= bus.in_last;
        act_empty <= in_empty;
      end else if (load_from_pend) begin
        act       <= pend;
        cnt       <= 3'd0;
        lim       <= pend_lim;
        act_last  <= pend_last;
        act_empty <= pend_empty;
      end else if (shift) begin
        act <= {act[BYTE_W+1:BLK_W], {BYTE_W{1'b0}}};
        cnt <= cnt + 3'd1;
      end else if (retire) begin
        act_empty <= 1'b0;
      end

      if (load_pend) begin
        pend       <= bus.in_block;
        pend_full  <= 1'b1;
        pend_lim   <= in_lim;
        pend_last  <= bus.in_last;
        pend_empty <= in_empty;
      end else if (load_from_pend) begin
        pend_full <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = !pend_full;
  assign bus.out_valid = out_valid;
  assign bus.out_byte  = act[1:BYTE_W];
  assign bus.out_last  = out_valid && act_last && blk_end;
  assign bus.done      = done_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_des_block_serializer.sv
// Directed bench for des_block_serializer: expected bytes queued at issue, popped by a monitor.
module tb_des_block_serializer;
  import des_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  state_t dbg_state;

  des_block_serializer_if bus();

  des_block_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not end, required finish");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int         checks   = 0;
  int         errors   = 0;
  int         done_cnt = 0;
  int         hs_cnt   = 0;
  logic [8:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic       last_hs_d;
    logic       stall_d;
    logic [7:0] byte_d;
    logic [8:0] e;
    last_hs_d = 1'b0;
    stall_d   = 1'b0;
    byte_d    = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_hs_d = 1'b0;
        stall_d   = 1'b0;
      end else begin
        if (last_hs_d) check("done_after_last", 64'(bus.done), 64'd1);
        if (bus.done) done_cnt++;
        if (stall_d) begin
          check("stall_valid", 64'(bus.out_valid), 64'd1);
          check("stall_byte", 64'(bus.out_byte), 64'(byte_d));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %0h, required no byte", bus.out_byte);
          end else begin
            e = exp_q.pop_front();
            check("out_byte", 64'(bus.out_byte), 64'(e[7:0]));
            check("out_last", 64'(bus.out_last), 64'(e[8]));
          end
          hs_cnt++;
        end
        last_hs_d = bus.out_valid && bus.out_ready && bus.out_last;
        stall_d   = bus.out_valid && !bus.out_ready;
        byte_d    = bus.out_byte;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // nbytes is the hand-computed number of bytes the block should emit.
  task automatic send_block(input logic [63:0] blk, input logic last, input int nbytes);
    logic acc;
    int   guard;
    logic [7:0] b;
    bus.in_block = blk;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    for (int i = 0; i < nbytes; i++) begin
      b = blk[63-8*i -: 8];
      exp_q.push_back({(last && (i == nbytes - 1)), b});
    end
    acc   = 1'b0;
    guard = 0;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1");
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && guard < 300) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 300) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d bytes outstanding, required 0", exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    int h0;
    bus.in_block  = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_byte", 64'(bus.out_byte), 64'd0);
    check("rst_out_last", 64'(bus.out_last), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_pad_err", 64'(bus.pad_err), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // single block, first byte one cycle after accept, 8 contiguous bytes
    d0 = done_cnt;
    send_block(64'h0123456789ABCDEF, 1'b0, 8);
    check("t1_latency_valid", 64'(bus.out_valid), 64'd1);
    check("t1_first_byte", 64'(bus.out_byte), 64'h01);
    for (int i = 1; i < 8; i++) begin
      @(posedge clk);
      #1;
      check("t1_contiguous", 64'(bus.out_valid), 64'd1);
    end
    @(posedge clk);
    #1;
    check("t1_idle_after", 64'(bus.out_valid), 64'd0);
    wait_drain();
    check("t1_no_done", 64'(done_cnt), 64'(d0));

    // two back-to-back blocks, no bubble, in_ready low only while PEND full
    d0 = done_cnt;
    send_block(64'h1122334455667788, 1'b0, 8);
    send_block(64'h99AABBCCDDEEFF00, 1'b1, 8);
    check("t2_pend_full", 64'(bus.in_ready), 64'd0);
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
      check("t2_no_bubble", 64'(bus.out_valid), 64'd1);
      check("t2_in_ready", 64'(bus.in_ready), (i + 2 >= 8) ? 64'd1 : 64'd0);
    end
    wait_drain();
    check("t2_done", 64'(done_cnt), 64'(d0 + 1));

    // out_ready toggling mid-block
    d0 = done_cnt;
    fork
      send_block(64'hDEADBEEFCAFEF00D, 1'b1, 8);
      begin
        repeat (24) begin
          @(posedge clk);
          #1;
          bus.out_ready = ~bus.out_ready;
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();
    check("t3_done", 64'(done_cnt), 64'(d0 + 1));

`ifdef DES_PAD_STRIP_EN
    d0 = done_cnt;
    send_block(64'h4142430505050505, 1'b1, 3);
    wait_drain();
    check("pad5_err", 64'(bus.pad_err), 64'd0);
    check("pad5_done", 64'(done_cnt), 64'(d0 + 1));

    d0 = done_cnt;
    send_block(64'h0102030405060708, 1'b0, 8);
    send_block(64'h0808080808080808, 1'b1, 0);
    wait_drain();
    check("pad8_done", 64'(done_cnt), 64'(d0 + 1));
    check("pad8_err", 64'(bus.pad_err), 64'd0);

    d0 = done_cnt;
    send_block(64'h1111111111110304, 1'b1, 8);
    wait_drain();
    check("padbad_err", 64'(bus.pad_err), 64'd1);
    check("padbad_done", 64'(done_cnt), 64'(d0 + 1));
`else
    d0 = done_cnt;
    send_block(64'h4142430505050505, 1'b1, 8);
    wait_drain();
    send_block(64'h0808080808080808, 1'b1, 8);
    wait_drain();
    send_block(64'h1111111111110304, 1'b1, 8);
    wait_drain();
    check("nopad_err", 64'(bus.pad_err), 64'd0);
    check("nopad_done", 64'(done_cnt), 64'(d0 + 3));
`endif

    // reset mid-drain with PEND full after 3 bytes
    d0 = done_cnt;
    h0 = hs_cnt;
    send_block(64'h0011223344556677, 1'b0, 8);
    send_block(64'h8899AABBCCDDEEFF, 1'b0, 8);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("t4_bytes_before_rst", 64'(hs_cnt - h0), 64'd3);
    check("t4_pend_full", 64'(bus.in_ready), 64'd0);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("t4_out_valid", 64'(bus.out_valid), 64'd0);
    check("t4_in_ready", 64'(bus.in_ready), 64'd1);
    check("t4_out_byte", 64'(bus.out_byte), 64'd0);
    check("t4_out_last", 64'(bus.out_last), 64'd0);
    check("t4_pad_err", 64'(bus.pad_err), 64'd0);
    check("t4_state", 64'(dbg_state), 64'(IDLE));
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_block(64'hA0A1A2A3A4A5A6A7, 1'b1, 8);
    check("t4_restart_byte0", 64'(bus.out_byte), 64'hA0);
    wait_drain();
    check("t4_done", 64'(done_cnt), 64'(d0 + 1));
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/des_block_serializer.md
Name: des_block_serializer

Overview:
- Consumes 64-bit plaintext blocks from the single-DES decrypt core.
- Serialises each block into a byte stream, byte 0 first, for the steganography image writer.
- Double-buffered, so it accepts the next block while the current one drains: 1 byte/cycle sustained, no bubble between blocks.
- Valid/ready handshake on both sides.

Parameters:
- BLK_W, 64, block width in bits (fixed; 8 bytes per block)
- BYTE_W, 8, output byte width

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_block  in  [1:64]  decrypted block; bits 1..8 = byte 0, bits 57..64 = byte 7
- in_valid  in  1  in_block/in_last valid
- in_last  in  1  block is the final block of the message
- in_ready  out  1  block accepted when in_valid & in_ready
- out_byte  out  [1:8]  current byte; bit 1 = MSB
- out_valid  out  1  out_byte valid
- out_last  out  1  final byte of the message
- out_ready  in  1  byte consumed when out_valid & out_ready
- done  out  1  one-cycle pulse when the last block retires
- pad_err  out  1  sticky pad error; tied 0 when DES_PAD_STRIP_EN is undefined

Behaviour:
- Storage: active shift register ACT with byte counter cnt (0..7) and byte limit lim; pending register PEND with a full flag and a last flag.
- States:
  - IDLE: ACT empty.
  - DRAIN: ACT holds bytes.
- in_ready = !pend_full, a registered flag with no combinational path from out_ready.
- Accept in IDLE: block loads directly into ACT. Next cycle: state DRAIN, cnt=0, out_valid=1. Latency: accept edge to first byte valid = 1 cycle.
- Accept in DRAIN: block goes to PEND.
- Byte handshake in DRAIN with cnt<lim: ACT shifts left 8 bits; cnt increments.
- Byte handshake with cnt==lim (block exhausted):
  - If PEND is full: PEND moves to ACT in the same edge; cnt=0; out_valid stays 1.
  - Otherwise: state returns to IDLE.
- Simultaneous block exhaustion and new accept with PEND empty: the new block loads straight into ACT. No bubble.
- out_byte = ACT[1:8]. It is held stable while out_valid & !out_ready. out_valid is never dropped without a handshake.
- out_last = out_valid & act_last & (cnt==lim).
- done pulses one cycle after the out_last handshake.
- lim = 7 unless changed by the optional feature.
- Reset, including mid-drain: state=IDLE, pend_full=0, cnt=0, ACT=0, PEND=0. Outputs in_ready=1, out_valid=0, out_byte=0, out_last=0, done=0, pad_err=0. Partially sent blocks are discarded.
- No overflow is possible: in_ready gates every write.

Optional Feature:
- Macro DES_PAD_STRIP_EN.
- Defined: PKCS#5 padding is stripped on blocks with in_last=1. N = byte 7 (in_block[57:64]).
  - Pad is valid iff 1<=N<=8 and bytes 8-N..7 all equal N.
  - Valid, N<8: lim = 7-N.
  - Valid, N==8: the block emits no bytes. It retires on the cycle it reaches ACT, and done pulses the next cycle. The previous block's final byte was already sent without out_last.
  - Invalid: lim=7, all 8 bytes emitted with out_last on byte 7, pad_err set (sticky until rst).
  - The pad check is computed at acceptance and stored with the block.
- Undefined: lim is always 7; pad_err=0. No pad logic is synthesised.

Decomposition:
- Shared package des_pkg:
  - constants BLK_W=64, BYTE_W=8, BYTES_PER_BLK=8
  - state enum {IDLE, DRAIN}
  - pad-check function (N extraction and validation)
- One natural sub-module: des_pad_check. It is combinational: in_block in, lim_out/pad_ok/empty_blk out. It is instantiated only under DES_PAD_STRIP_EN.

Test Plan:
- Single block 0x0123456789ABCDEF, out_ready=1 -> bytes 01,23,45,67,89,AB,CD,EF on 8 consecutive cycles starting 1 cycle after accept; no out_last unless in_last.
- Two back-to-back blocks, second with in_last=1, out_ready=1 -> 16 contiguous bytes, no gap; out_last on byte 16; done pulses the next cycle; in_ready low only while PEND is full.
- out_ready toggled 1010... mid-block -> out_byte stable while stalled; order preserved; no byte lost or duplicated.
- rst asserted after 3 bytes sent with PEND full -> next cycle out_valid=0, in_ready=1; a new block afterwards starts at its byte 0.
- DES_PAD_STRIP_EN, last block 0x4142430505050505 -> bytes 41,42,43, out_last on 43, pad_err=0.
- DES_PAD_STRIP_EN:
  - Last block 0x0808080808080808 -> no bytes; done pulses.
  - Last block ending 0x...0304 (invalid) -> 8 bytes emitted, pad_err=1.
